// File: rtl/qm_execute.sv
// qm_execute -- execute stage: single-cycle ALU plus an optional iterative
// multiply/divide unit that owns the HI/LO registers.
//
// Build option:
//   QM_MULDIV_EN  defined   -> mul/div FSM, HI/LO registers and MFHI/MFLO
//                              interlock are built.
//                 undefined -> no FSM, no HI/LO. Mul/div codes retire as
//                              non-writing slots, MFHI/MFLO read 0, co_Stall
//                              is tied low.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   di_RSVal/di_RTVal     operands (RT is also the store data)
//   di_Imm                sign-extended immediate, shamt = di_Imm[10:6]
//   di_RT/di_RD           destination register candidates
//   ci_*                  decode-slot controls
//   do_*/co_*             registered EX/MEM outputs
//   co_Stall              combinational; upstream holds its inputs while high
//
// Mul/div FSM (QM_MULDIV_EN only):
//   state | meaning
//   IDLE  | no operation in flight, HI/LO stable
//   BUSY  | one multiply/divide bit per cycle, 32 cycles
//   DONE  | sign-correct result and write HI/LO

module qm_execute (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] di_RSVal,
    input  logic [31:0] di_RTVal,
    input  logic [31:0] di_Imm,
    input  logic [4:0]  di_RT,
    input  logic [4:0]  di_RD,
    input  logic        ci_Valid,
    input  logic [3:0]  ci_ALUControl,
    input  logic        ci_ALUSource,
    input  logic        ci_RegDest,
    input  logic        ci_RegWrite,
    input  logic        ci_MemWrite,
    input  logic        ci_RegWSource,
    input  logic [1:0]  ci_HiLoSel,
    output logic [31:0] do_ALUResult,
    output logic [31:0] do_WriteData,
    output logic [4:0]  do_WA,
    output logic        co_Valid,
    output logic        co_RegWrite,
    output logic        co_MemWrite,
    output logic        co_RegWSource,
    output logic        co_Overflow,
    output logic        co_Stall
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_ADDU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        is_mf;
    logic        is_muldiv;
    logic        accept;
    logic [31:0] hi_val;
    logic [31:0] lo_val;
    logic [31:0] ex_res;

    assign op_b    = ci_ALUSource ? di_Imm : di_RTVal;
    assign shamt   = di_Imm[10:6];
    assign add_res = di_RSVal + op_b;
    assign sub_res = di_RSVal - op_b;

    // HiLoSel 11 is reserved and behaves like 00.
    assign is_mf     = (ci_HiLoSel == 2'b01) || (ci_HiLoSel == 2'b10);
    assign is_muldiv = (ci_ALUControl[3:2] == 2'b11) && !is_mf;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ci_ALUControl)
            OP_AND:  alu_res = di_RSVal & op_b;
            OP_OR:   alu_res = di_RSVal | op_b;
            OP_XOR:  alu_res = di_RSVal ^ op_b;
            OP_NOR:  alu_res = ~(di_RSVal | op_b);
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (di_RSVal[31] == op_b[31]) && (add_res[31] != di_RSVal[31]);
            end
            OP_ADDU: alu_res = add_res;
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (di_RSVal[31] != op_b[31]) && (sub_res[31] != di_RSVal[31]);
            end
            OP_SLT:  alu_res = {31'b0, $signed(di_RSVal) < $signed(op_b)};
            OP_SLTU: alu_res = {31'b0, di_RSVal < op_b};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
            default: alu_res = '0;
        endcase
        if (is_mf) begin
            alu_ovf = 1'b0;
        end
    end

    assign ex_res = is_mf ? ((ci_HiLoSel == 2'b01) ? hi_val : lo_val) : alu_res;
    assign accept = ci_Valid && !co_Stall;

`ifdef QM_MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t   md_state;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] md_acc;
    logic [31:0] md_opnd;
    logic [31:0] md_dvd;
    logic [4:0]  md_cnt;
    logic        md_is_div;
    logic        md_neg_q;
    logic        md_neg_r;
    logic        md_div0;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] mul_next;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Bit 0 of the code selects the unsigned variant.
    assign a_neg = !ci_ALUControl[0] && di_RSVal[31];
    assign b_neg = !ci_ALUControl[0] && di_RTVal[31];
    assign a_mag = a_neg ? (~di_RSVal + 32'd1) : di_RSVal;
    assign b_mag = b_neg ? (~di_RTVal + 32'd1) : di_RTVal;

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign mul_sum  = {1'b0, md_acc[63:32]} + (md_acc[0] ? {1'b0, md_opnd} : 33'd0);
    assign mul_next = {mul_sum, md_acc[31:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}.
    assign div_trial = {md_acc[63:32], md_acc[31]} - {1'b0, md_opnd};
    assign div_next  = div_trial[32] ? {md_acc[62:0], 1'b0}
                                     : {div_trial[31:0], md_acc[30:0], 1'b1};

    assign prod_fix = md_neg_q ? (~md_acc + 64'd1) : md_acc;
    assign quo_fix  = md_neg_q ? (~md_acc[31:0] + 32'd1) : md_acc[31:0];
    assign rem_fix  = md_neg_r ? (~md_acc[63:32] + 32'd1) : md_acc[63:32];

    assign hi_val   = hi_q;
    assign lo_val   = lo_q;
    assign co_Stall = !reset && ci_Valid && (md_state != MD_IDLE) && (is_mf || is_muldiv);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_state  <= MD_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            md_acc    <= '0;
            md_opnd   <= '0;
            md_dvd    <= '0;
            md_cnt    <= '0;
            md_is_div <= 1'b0;
            md_neg_q  <= 1'b0;
            md_neg_r  <= 1'b0;
            md_div0   <= 1'b0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (accept && is_muldiv) begin
                        md_state  <= MD_BUSY;
                        md_cnt    <= 5'd31;
                        md_acc    <= {32'b0, a_mag};
                        md_opnd   <= b_mag;
                        md_dvd    <= di_RSVal;
                        md_is_div <= ci_ALUControl[1];
                        md_neg_q  <= a_neg ^ b_neg;
                        md_neg_r  <= a_neg;
                        md_div0   <= (di_RTVal == 32'd0);
                    end
                end
                MD_BUSY: begin
                    md_acc <= md_is_div ? div_next : mul_next;
                    if (md_cnt == 5'd0) begin
                        md_state <= MD_DONE;
                    end else begin
                        md_cnt <= md_cnt - 5'd1;
                    end
                end
                MD_DONE: begin
                    if (!md_is_div) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (md_div0) begin
                        hi_q <= md_dvd;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    md_state <= MD_IDLE;
                end
                default: md_state <= MD_IDLE;
            endcase
        end
    end
`else
    assign hi_val   = '0;
    assign lo_val   = '0;
    assign co_Stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            co_Valid      <= 1'b0;
            co_RegWrite   <= 1'b0;
            co_MemWrite   <= 1'b0;
            co_RegWSource <= 1'b0;
            co_Overflow   <= 1'b0;
            do_ALUResult  <= '0;
            do_WriteData  <= '0;
            do_WA         <= '0;
        end else begin
            co_Valid      <= accept;
            co_RegWrite   <= accept && ci_RegWrite && !is_muldiv && !alu_ovf;
            co_MemWrite   <= accept && ci_MemWrite && !is_muldiv;
            co_RegWSource <= accept && ci_RegWSource;
            co_Overflow   <= accept && alu_ovf;
            if (accept) begin
                do_ALUResult <= ex_res;
                do_WriteData <= di_RTVal;
                do_WA        <= ci_RegDest ? di_RD : di_RT;
            end
        end
    end

endmodule

// File: tb/tb_qm_execute.sv
module tb_qm_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] di_RSVal, di_RTVal, di_Imm;
    logic [4:0]  di_RT, di_RD;
    logic        ci_Valid;
    logic [3:0]  ci_ALUControl;
    logic        ci_ALUSource, ci_RegDest, ci_RegWrite, ci_MemWrite, ci_RegWSource;
    logic [1:0]  ci_HiLoSel;
    logic [31:0] do_ALUResult, do_WriteData;
    logic [4:0]  do_WA;
    logic        co_Valid, co_RegWrite, co_MemWrite, co_RegWSource, co_Overflow, co_Stall;

    int n_cmp = 0;
    int n_err = 0;
    int stalls;

    qm_execute dut (
        .clk(clk), .reset(reset),
        .di_RSVal(di_RSVal), .di_RTVal(di_RTVal), .di_Imm(di_Imm),
        .di_RT(di_RT), .di_RD(di_RD),
        .ci_Valid(ci_Valid), .ci_ALUControl(ci_ALUControl),
        .ci_ALUSource(ci_ALUSource), .ci_RegDest(ci_RegDest),
        .ci_RegWrite(ci_RegWrite), .ci_MemWrite(ci_MemWrite),
        .ci_RegWSource(ci_RegWSource), .ci_HiLoSel(ci_HiLoSel),
        .do_ALUResult(do_ALUResult), .do_WriteData(do_WriteData), .do_WA(do_WA),
        .co_Valid(co_Valid), .co_RegWrite(co_RegWrite), .co_MemWrite(co_MemWrite),
        .co_RegWSource(co_RegWSource), .co_Overflow(co_Overflow), .co_Stall(co_Stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] imm, input logic [1:0] hl);
        ci_Valid      = 1'b1;
        ci_ALUControl = op;
        di_RSVal      = a;
        di_RTVal      = b;
        ci_ALUSource  = src;
        di_Imm        = imm;
        ci_HiLoSel    = hl;
        ci_RegWrite   = 1'b1;
        ci_MemWrite   = 1'b0;
        ci_RegWSource = 1'b0;
        ci_RegDest    = 1'b1;
        di_RT         = 5'd3;
        di_RD         = 5'd7;
    endtask

    // Issue MFHI/MFLO and ride out any interlock (bounded), then check the value.
    task automatic wait_mf(input string tag, input logic [1:0] hl, input logic [31:0] exp,
                           output int n_stall);
        drive(4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, hl);
        #1;
        n_stall = 0;
        while (co_Stall && n_stall < 100) begin
            step();
            n_stall++;
            if (n_stall == 1) chk({tag, "_bubble_valid"}, {31'b0, co_Valid}, 32'd0);
        end
        if (n_stall >= 100) chk({tag, "_stall_timeout"}, {31'b0, co_Stall}, 32'd0);
        step();
        chk(tag, do_ALUResult, exp);
        ci_Valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(4'b1100, 32'd1, 32'd2, 1'b0, 32'd0, 2'b01);
        #1;
        chk("stall_in_reset", {31'b0, co_Stall}, 32'd0);
        step();
        step();
        chk("rst_valid", {31'b0, co_Valid}, 32'd0);
        chk("rst_regwrite", {31'b0, co_RegWrite}, 32'd0);
        chk("rst_result", do_ALUResult, 32'd0);
        chk("rst_wdata", do_WriteData, 32'd0);
        chk("rst_wa", {27'b0, do_WA}, 32'd0);
        reset = 1'b0;

        drive(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'd0, 2'b00);
        step();
        chk("and_res", do_ALUResult, 32'h00F0_1200);
        chk("and_wa_rd", {27'b0, do_WA}, 32'd7);
        chk("and_wdata", do_WriteData, 32'h0FF0_FF00);
        chk("and_valid", {31'b0, co_Valid}, 32'd1);
        chk("and_regwrite", {31'b0, co_RegWrite}, 32'd1);

        drive(4'b0001, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b1, 32'h0000_000F, 2'b00);
        step();
        chk("ori_res", do_ALUResult, 32'h0000_00FF);
        chk("ori_wdata", do_WriteData, 32'hDEAD_BEEF);

        drive(4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 32'd0, 2'b00);
        step();
        chk("xor_res", do_ALUResult, 32'hF0F0_0F0F);

        drive(4'b0100, 32'h0000_FFFF, 32'h00FF_0000, 1'b0, 32'd0, 2'b00);
        step();
        chk("nor_res", do_ALUResult, 32'hFF00_0000);

        drive(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b00);
        step();
        chk("add_ovf_flag", {31'b0, co_Overflow}, 32'd1);
        chk("add_ovf_regwrite", {31'b0, co_RegWrite}, 32'd0);

        drive(4'b0101, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b00);
        step();
        chk("addu_res", do_ALUResult, 32'h8000_0000);
        chk("addu_ovf", {31'b0, co_Overflow}, 32'd0);
        chk("addu_regwrite", {31'b0, co_RegWrite}, 32'd1);

        drive(4'b0010, 32'd5, 32'hFFFF_FFFD, 1'b0, 32'd0, 2'b00);
        step();
        chk("add_res", do_ALUResult, 32'd2);
        chk("add_no_ovf", {31'b0, co_Overflow}, 32'd0);

        drive(4'b0110, 32'h8000_0000, 32'd1, 1'b0, 32'd0, 2'b00);
        step();
        chk("sub_ovf_flag", {31'b0, co_Overflow}, 32'd1);
        chk("sub_ovf_regwrite", {31'b0, co_RegWrite}, 32'd0);

        drive(4'b0110, 32'd3, 32'd5, 1'b0, 32'd0, 2'b00);
        step();
        chk("sub_res", do_ALUResult, 32'hFFFF_FFFE);
        chk("sub_no_ovf", {31'b0, co_Overflow}, 32'd0);

        drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b00);
        step();
        chk("slt_res", do_ALUResult, 32'd1);

        drive(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b00);
        step();
        chk("sltu_res0", do_ALUResult, 32'd0);

        drive(4'b1000, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 2'b00);
        step();
        chk("sltu_res1", do_ALUResult, 32'd1);

        drive(4'b1001, 32'd0, 32'd1, 1'b0, 32'h0000_0100, 2'b00);
        step();
        chk("sll_res", do_ALUResult, 32'h0000_0010);

        drive(4'b1010, 32'd0, 32'h8000_0000, 1'b0, 32'h0000_07C0, 2'b00);
        step();
        chk("srl_res", do_ALUResult, 32'd1);

        drive(4'b1011, 32'd0, 32'h8000_0000, 1'b0, 32'h0000_0100, 2'b00);
        step();
        chk("sra_res", do_ALUResult, 32'hF800_0000);

        drive(4'b0001, 32'd1, 32'd2, 1'b0, 32'd0, 2'b00);
        ci_RegDest    = 1'b0;
        ci_MemWrite   = 1'b1;
        ci_RegWSource = 1'b1;
        step();
        chk("rt_dest_wa", {27'b0, do_WA}, 32'd3);
        chk("memwrite_pass", {31'b0, co_MemWrite}, 32'd1);
        chk("regwsrc_pass", {31'b0, co_RegWSource}, 32'd1);

        ci_Valid = 1'b0;
        step();
        chk("bubble_valid", {31'b0, co_Valid}, 32'd0);
        chk("bubble_regwrite", {31'b0, co_RegWrite}, 32'd0);
        chk("bubble_memwrite", {31'b0, co_MemWrite}, 32'd0);

        drive(4'b1100, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0, 2'b00);
        ci_MemWrite = 1'b1;
        #1;
        chk("mult_issue_stall", {31'b0, co_Stall}, 32'd0);
        step();
        chk("mult_valid", {31'b0, co_Valid}, 32'd1);
        chk("mult_regwrite", {31'b0, co_RegWrite}, 32'd0);
        chk("mult_memwrite", {31'b0, co_MemWrite}, 32'd0);

`ifndef QM_MULDIV_EN
        drive(4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 2'b01);
        #1;
        chk("mfhi_nomd_stall", {31'b0, co_Stall}, 32'd0);
        step();
        chk("mfhi_nomd_res", do_ALUResult, 32'd0);
        chk("mfhi_nomd_regwrite", {31'b0, co_RegWrite}, 32'd1);
        drive(4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 2'b10);
        #1;
        chk("mflo_nomd_stall", {31'b0, co_Stall}, 32'd0);
        step();
        chk("mflo_nomd_res", do_ALUResult, 32'd0);
`else
        // MULT -3 x 7 was just accepted; MFLO follows immediately.
        wait_mf("mult_lo", 2'b10, 32'hFFFF_FFEB, stalls);
        chk("mult_stall_cycles", stalls, 32'd33);
        wait_mf("mult_hi", 2'b01, 32'hFFFF_FFFF, stalls);

        drive(4'b1110, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 2'b00);
        step();
        wait_mf("div_lo", 2'b10, 32'hFFFF_FFFD, stalls);
        wait_mf("div_hi", 2'b01, 32'hFFFF_FFFF, stalls);

        drive(4'b1111, 32'd5, 32'd0, 1'b0, 32'd0, 2'b00);
        step();
        wait_mf("divu0_lo", 2'b10, 32'hFFFF_FFFF, stalls);
        wait_mf("divu0_hi", 2'b01, 32'd5, stalls);

        drive(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 2'b00);
        step();
        wait_mf("divmin_lo", 2'b10, 32'h8000_0000, stalls);
        wait_mf("divmin_hi", 2'b01, 32'd0, stalls);

        drive(4'b1101, 32'd5, 32'd6, 1'b0, 32'd0, 2'b00);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(4'b0001, i, 32'h0000_0100, 1'b0, 32'd0, 2'b00);
            #1;
            chk("or_busy_stall", {31'b0, co_Stall}, 32'd0);
            step();
            chk("or_busy_res", do_ALUResult, 32'h0000_0100 | i);
            chk("or_busy_valid", {31'b0, co_Valid}, 32'd1);
        end
        wait_mf("multu_lo", 2'b10, 32'd30, stalls);

        drive(4'b1110, 32'd100, 32'd7, 1'b0, 32'd0, 2'b00);
        step();
        ci_Valid = 1'b0;
        repeat (16) step();
        reset = 1'b1;
        drive(4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 2'b01);
        #1;
        chk("stall_reset_busy", {31'b0, co_Stall}, 32'd0);
        step();
        reset = 1'b0;
        drive(4'b0000, 32'd0, 32'd0, 1'b0, 32'd0, 2'b01);
        #1;
        chk("post_rst_stall", {31'b0, co_Stall}, 32'd0);
        step();
        chk("post_rst_hi", do_ALUResult, 32'd0);
        wait_mf("post_rst_lo", 2'b10, 32'd0, stalls);
        chk("post_rst_lo_stalls", stalls, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qm_execute.md
QM_EXECUTE -- requirements
Module: qm_execute

Interface
REQ-001 Parameters: none; all widths fixed (32-bit datapath, 5-bit register addresses).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 di_RSVal  in  32  RS operand from decode/execute register.
REQ-005 di_RTVal  in  32  RT operand; also store data.
REQ-006 di_Imm  in  32  sign-extended immediate; shamt taken from bits [10:6].
REQ-007 di_RT / di_RD  in  5 each  candidate destination register numbers.
REQ-008 ci_Valid  in  1  decode slot holds a real instruction.
REQ-009 ci_ALUControl  in  4  operation code (REQ-017).
REQ-010 ci_ALUSource  in  1  0: B=di_RTVal, 1: B=di_Imm.
REQ-011 ci_RegDest  in  1  0: WA=di_RT, 1: WA=di_RD.
REQ-012 ci_RegWrite, ci_MemWrite, ci_RegWSource  in  1 each  controls passed to memory stage.
REQ-013 ci_HiLoSel  in  2  00 none, 01 MFHI, 10 MFLO, 11 reserved (treated as 00).
REQ-014 do_ALUResult, do_WriteData  out  32 each; do_WA  out  5  registered EX/MEM outputs.
REQ-015 co_Valid, co_RegWrite, co_MemWrite, co_RegWSource, co_Overflow  out  1 each  registered.
REQ-016 co_Stall  out  1  combinational; upstream SHALL hold all inputs while high.

Function
REQ-017 Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 ADDU, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
REQ-018 ALU ops: one-cycle latency; result on outputs the edge after acceptance.
REQ-019 Shifts operate on B by di_Imm[10:6]; SRA sign-fills; SLT signed, SLTU unsigned, result 0 or 1.
REQ-020 ADD/SUB signed overflow: co_Overflow=1 for that slot, co_RegWrite forced 0; ADDU never flags.
REQ-021 do_WriteData = di_RTVal unmodified; do_WA per ci_RegDest.
REQ-022 MFHI/MFLO: do_ALUResult = HI/LO, co_RegWrite as supplied.
REQ-023 Mul/div FSM states: IDLE, BUSY, DONE. IDLE->BUSY on accepted mul/div; BUSY iterates 1 bit per cycle for 32 cycles; BUSY->DONE after 32nd; DONE writes HI/LO (sign-corrected) and returns to IDLE next edge.
REQ-024 Accepted mul/div slot leaves with co_Valid=1, co_RegWrite=0, co_MemWrite=0.
REQ-025 co_Stall=1 iff ci_Valid and FSM not IDLE and (ci_HiLoSel!=00 or new mul/div); otherwise 0.
REQ-026 Independent ALU ops proceed while FSM busy, no stall.
REQ-027 While co_Stall=1: next edge emits bubble (co_Valid=0, all co_* write enables 0).
REQ-028 ci_Valid=0: bubble emitted, FSM unaffected.
REQ-029 MULT: {HI,LO}=signed 64-bit product; MULTU unsigned.
REQ-030 DIV/DIVU: LO=quotient, HI=remainder; remainder takes dividend sign (truncating division).
REQ-031 Divide by zero: LO=32'hFFFFFFFF, HI=dividend; no exception.
REQ-032 DIV 0x80000000 / -1: LO=0x80000000, HI=0.
REQ-033 MFHI/MFLO accepted in the same cycle FSM is in DONE: stalled one cycle, then returns new value.

Reset
REQ-034 On reset: co_Valid, co_RegWrite, co_MemWrite, co_RegWSource, co_Overflow=0; do_ALUResult, do_WriteData=0; do_WA=0.
REQ-035 On reset: FSM->IDLE, HI=LO=0, iteration counter=0; in-flight mul/div aborted, no HI/LO update.
REQ-036 co_Stall=0 during reset cycle.

Configuration
REQ-037 Macro QM_MULDIV_EN: defined -> REQ-023..REQ-033 implemented.
REQ-038 Undefined -> no FSM/HI/LO logic; codes 1100-1111 emit co_Valid=1, co_RegWrite=0; MFHI/MFLO return 0; co_Stall tied 0.

Verification
REQ-039 ADD 0x7FFFFFFF+1 -> co_Overflow=1, co_RegWrite=0, next edge; ADDU same -> result 0x80000000, no overflow.
REQ-040 MULT -3 x 7 then MFLO next cycle -> MFLO stalls 32+ cycles, LO=0xFFFFFFEB, HI=0xFFFFFFFF.
REQ-041 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-042 MULTU issued, then 10 back-to-back ORs -> no stall, ORs emerge 1 cycle each, co_Valid=1.
REQ-043 Reset asserted at iteration 16 of DIV -> FSM IDLE, HI=LO=0, next MFHI returns 0 without stall.
REQ-044 Build without QM_MULDIV_EN: MULT then MFHI -> co_Stall never 1, MFHI result 0.
